// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// FSM encoding and default operand width.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/serial_adder_bitadder.sv
// One-bit full adder cell used by the serial adder datapath.
// Combinational; sum and carry of two bits plus carry-in.
module bitAdder (
   input  logic bit1,
   input  logic bit2,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = bit1 ^ bit2 ^ cin;
   assign cout = (bit1 & bit2) | (cin & (bit1 ^ bit2));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder, LSB first, one bit per clock through one bitAdder.
// Optional two's-complement overflow port under SERIAL_ADDER_OVF_EN.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             overflow
`endif
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t state_q, state_d;

   logic [WIDTH-1:0] sra, srb;
   logic [WIDTH-2:0] acc;
   logic [CW-1:0]    cnt;
   logic             cy;
   logic             accept;
   logic             last;
   logic             s_bit;
   logic             c_bit;
   logic [WIDTH-1:0] nxt;

   bitAdder u_bit (
      .bit1 (sra[0]),
      .bit2 (srb[0]),
      .cin  (cy),
      .sum  (s_bit),
      .cout (c_bit)
   );

   assign last = (cnt == LAST);
   assign nxt  = {s_bit, acc};

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      accept  = 1'b0;
      unique case (1'b1)
         (state_q == RUN): begin
            busy = 1'b1;
            if (last) state_d = DONE;
         end
         (state_q == DONE): begin
            done    = 1'b1;
            accept  = start;
            state_d = start ? RUN : IDLE;
         end
         default: begin
            accept = start;
            state_d = start ? RUN : IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sra     <= '0;
         srb     <= '0;
         acc     <= '0;
         cnt     <= '0;
         cy      <= 1'b0;
         sum     <= '0;
         cout    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            sra <= a;
            srb <= b;
            cy  <= cin;
            cnt <= '0;
         end else if (busy) begin
            sra <= sra >> 1;
            srb <= srb >> 1;
            acc <= nxt[WIDTH-1:1];
            cy  <= c_bit;
            cnt <= cnt + CW'(1);
            // Publish the result on the last bit so it lands with DONE
            if (last) begin
               sum  <= nxt;
               cout <= c_bit;
            end
         end
      end
   end

`ifdef SERIAL_ADDER_OVF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
      end else if (busy && last && !accept) begin
         overflow <= cy ^ c_bit;
      end
   end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8).
// Overflow checks compile in with SERIAL_ADDER_OVF_EN.
module tb_serial_adder;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic       busy;
   logic       done;
   logic [7:0] sum;
   logic       cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic       overflow;
`endif

   int checks;
   int failures;

   serial_adder #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .overflow (overflow)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // lat = index of the rising edge (after the accepting one) that samples done
   task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                         input logic ci, output int lat, output int nbusy);
      int n;
      lat   = -1;
      nbusy = 0;
      n     = 0;
      @(negedge clk);
      start = 1'b1;
      a     = av;
      b     = bv;
      cin   = ci;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (busy && done) begin
            checks++;
            failures++;
            $display("FAIL busy_done_overlap busy=%b done=%b required not both",
                     busy, done);
         end
         if (busy) nbusy++;
         if (done) begin
            lat = n + 1;
            break;
         end
         @(posedge clk);
         n++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b1;
      a     = 8'hAA;
      b     = 8'h55;
      cin   = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({busy, done, sum, cout} !== 11'd0) begin
         failures++;
         $display("FAIL reset_outputs got busy=%b done=%b sum=%h cout=%b required all 0",
                  busy, done, sum, cout);
      end
      start = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_release_idle got busy=%b required 0", busy);
      end
   endtask

   task automatic test_basic();
      int lat, nb;
      run_op(8'h0F, 8'h01, 1'b0, lat, nb);
      checks++;
      if (lat !== 9) begin
         failures++;
         $display("FAIL basic_latency got %0d required 9", lat);
      end
      checks++;
      if (nb !== 8) begin
         failures++;
         $display("FAIL basic_busy_cycles got %0d required 8", nb);
      end
      checks++;
      if (sum !== 8'h10 || cout !== 1'b0) begin
         failures++;
         $display("FAIL basic_result got sum=%h cout=%b required 10 0", sum, cout);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL basic_return_idle got done=%b busy=%b required 0 0", done, busy);
      end
   endtask

   task automatic test_edges();
      int lat, nb;
      run_op(8'hFF, 8'h01, 1'b0, lat, nb);
      checks++;
      if (lat !== 9 || sum !== 8'h00 || cout !== 1'b1) begin
         failures++;
         $display("FAIL carry_out got lat=%0d sum=%h cout=%b required 9 00 1",
                  lat, sum, cout);
      end
      run_op(8'h00, 8'h00, 1'b1, lat, nb);
      checks++;
      if (lat !== 9 || sum !== 8'h01 || cout !== 1'b0) begin
         failures++;
         $display("FAIL carry_in got lat=%0d sum=%h cout=%b required 9 01 0",
                  lat, sum, cout);
      end
      run_op(8'hA5, 8'h5A, 1'b1, lat, nb);
      checks++;
      if (sum !== 8'h00 || cout !== 1'b1) begin
         failures++;
         $display("FAIL alt_pattern got sum=%h cout=%b required 00 1", sum, cout);
      end
      run_op(8'h3C, 8'h99, 1'b0, lat, nb);
      checks++;
      if (sum !== 8'hD5 || cout !== 1'b0) begin
         failures++;
         $display("FAIL mixed_pattern got sum=%h cout=%b required d5 0", sum, cout);
      end
   endtask

   task automatic test_start_ignored();
      int pulses, first;
      logic [7:0] rs;
      logic       rc;
      pulses = 0;
      first  = -1;
      rs     = 8'h00;
      rc     = 1'b1;
      @(negedge clk);
      start = 1'b1;
      a     = 8'h10;
      b     = 8'h20;
      cin   = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int n = 0; n < 24; n++) begin
         if (n == 3) begin
            start = 1'b1;
            a     = 8'h55;
            b     = 8'h55;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            pulses++;
            if (first < 0) begin
               first = n + 1;
               rs    = sum;
               rc    = cout;
            end
         end
         @(posedge clk);
         @(negedge clk);
      end
      start = 1'b0;
      checks++;
      if (pulses !== 1) begin
         failures++;
         $display("FAIL ignore_start_pulses got %0d required 1", pulses);
      end
      checks++;
      if (first !== 9 || rs !== 8'h30 || rc !== 1'b0) begin
         failures++;
         $display("FAIL ignore_start_result got lat=%0d sum=%h cout=%b required 9 30 0",
                  first, rs, rc);
      end
   endtask

   task automatic test_reset_mid();
      int lat, nb, pulses;
      pulses = 0;
      @(negedge clk);
      start = 1'b1;
      a     = 8'h10;
      b     = 8'h20;
      cin   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, sum, cout} !== 11'd0) begin
         failures++;
         $display("FAIL async_reset got busy=%b done=%b sum=%h cout=%b required all 0",
                  busy, done, sum, cout);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n < 15; n++) begin
         @(negedge clk);
         if (done || busy) pulses++;
      end
      checks++;
      if (pulses !== 0) begin
         failures++;
         $display("FAIL no_done_after_reset got %0d active cycles required 0", pulses);
      end
      run_op(8'h03, 8'h04, 1'b0, lat, nb);
      checks++;
      if (lat !== 9 || sum !== 8'h07 || cout !== 1'b0) begin
         failures++;
         $display("FAIL post_reset_op got lat=%0d sum=%h cout=%b required 9 07 0",
                  lat, sum, cout);
      end
   endtask

   task automatic test_overflow();
`ifdef SERIAL_ADDER_OVF_EN
      int lat, nb;
      run_op(8'h7F, 8'h01, 1'b0, lat, nb);
      checks++;
      if (sum !== 8'h80 || cout !== 1'b0 || overflow !== 1'b1) begin
         failures++;
         $display("FAIL ovf_set got sum=%h cout=%b ovf=%b required 80 0 1",
                  sum, cout, overflow);
      end
      run_op(8'hFF, 8'h01, 1'b0, lat, nb);
      checks++;
      if (sum !== 8'h00 || cout !== 1'b1 || overflow !== 1'b0) begin
         failures++;
         $display("FAIL ovf_clear got sum=%h cout=%b ovf=%b required 00 1 0",
                  sum, cout, overflow);
      end
`endif
   endtask

   task automatic test_back_to_back();
      int at[$];
      int n;
      n = 0;
      @(negedge clk);
      start = 1'b1;
      a     = 8'h01;
      b     = 8'h02;
      cin   = 1'b0;
      @(posedge clk);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (done) at.push_back(n + 1);
         if (busy && done) begin
            checks++;
            failures++;
            $display("FAIL b2b_overlap busy=%b done=%b required not both", busy, done);
         end
         @(posedge clk);
         n++;
      end
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (at.size() < 3) begin
         failures++;
         $display("FAIL b2b_pulse_count got %0d required >=3", at.size());
      end else begin
         checks++;
         if (at[0] !== 9) begin
            failures++;
            $display("FAIL b2b_first got %0d required 9", at[0]);
         end
         for (int k = 1; k < at.size(); k++) begin
            checks++;
            if (at[k] - at[k-1] !== 9) begin
               failures++;
               $display("FAIL b2b_spacing got %0d required 9", at[k] - at[k-1]);
            end
         end
      end
      checks++;
      if (sum !== 8'h03 || cout !== 1'b0) begin
         failures++;
         $display("FAIL b2b_result got sum=%h cout=%b required 03 0", sum, cout);
      end
      repeat (12) @(posedge clk);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_basic();
      test_edges();
      test_start_ignored();
      test_reset_mid();
      test_overflow();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout simulation exceeded 200000 time units");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  rising-edge system clock.
REQ-003 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request to begin an addition, sampled on clk rising edge.
REQ-005 SHALL have port a  input  WIDTH  operand A, captured when start is accepted.
REQ-006 SHALL have port b  input  WIDTH  operand B, captured when start is accepted.
REQ-007 SHALL have port cin  input  1  carry-in, captured when start is accepted.
REQ-008 SHALL have port busy  output  1  high while an addition is in progress.
REQ-009 SHALL have port done  output  1  single-cycle pulse when the result becomes valid.
REQ-010 SHALL have port sum  output  WIDTH  registered result, held until the next accepted start.
REQ-011 SHALL have port cout  output  1  registered carry-out of the MSB, held with sum.

Function
REQ-012 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-013 SHALL accept start only in IDLE or DONE, loading a and b into shift registers, cin into the carry flop, clearing the bit counter, and entering RUN.
REQ-014 SHALL, in RUN, add one bit pair per cycle LSB-first: operand LSBs and the carry flop feed one bitAdder, the sum bit shifts into the result MSB, and the carry flop takes the bitAdder cout.
REQ-015 SHALL leave RUN after exactly WIDTH cycles, enter DONE for one cycle with done=1, then return to IDLE unless start is accepted in DONE.
REQ-016 SHALL make sum and cout valid in the same cycle done is high; latency from the accepting clk edge to done is WIDTH+1 cycles.
REQ-017 SHALL assert busy in RUN only; busy and done SHALL never both be high.
REQ-018 SHALL ignore start while in RUN, with no effect on operands, counter or result.
REQ-019 SHALL, on start accepted in DONE, pulse done for that cycle and go back to RUN with no idle cycle.
REQ-020 SHALL compute sum = (a + b + cin) mod 2^WIDTH and cout = bit WIDTH of a + b + cin.
REQ-021 SHALL size the bit counter to $clog2(WIDTH+1) bits; it SHALL not wrap within one operation.

Reset
REQ-022 SHALL, on rst_n low and regardless of clk, force state IDLE, busy=0, done=0, sum=0, cout=0, counter=0 and carry flop=0.
REQ-023 SHALL abandon any addition in progress when reset is asserted mid-operation; after release, no done pulse occurs until a new start.
REQ-024 SHALL not accept start on the first clk edge at which rst_n is low.

Configuration
REQ-025 SHALL, with SERIAL_ADDER_OVF_EN defined, add port overflow (output, 1) meaning two's-complement overflow, equal to the carry into the MSB XOR cout, registered with sum, reset to 0 and held like sum.
REQ-026 SHALL, without SERIAL_ADDER_OVF_EN, have no overflow port and no overflow logic.

Structure
REQ-027 SHALL place the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH constant in shared package serial_adder_pkg.
REQ-028 SHALL instantiate exactly one existing bitAdder (ports bit1, bit2, cin, sum, cout) as its only sub-module; no other arithmetic primitive is used.

Verification
REQ-029 SHALL verify WIDTH=8, a=0x0F, b=0x01, cin=0 -> done 9 cycles after accepting edge, sum=0x10, cout=0, busy high for 8 cycles.
REQ-030 SHALL verify a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; and a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
REQ-031 SHALL verify start pulsed mid-RUN with a=0x55, b=0x55 during an operation on 0x10+0x20 -> result 0x30, cout=0, single done pulse.
REQ-032 SHALL verify rst_n low at RUN cycle 4 -> outputs 0 immediately, no done after release, next start 0x03+0x04 -> sum=0x07.
REQ-033 SHALL verify, with SERIAL_ADDER_OVF_EN, a=0x7F, b=0x01 -> sum=0x80, cout=0, overflow=1; a=0xFF, b=0x01 -> overflow=0.
REQ-034 SHALL verify start held high through DONE -> back-to-back operations with done pulses exactly 9 cycles apart.
